// File: rtl/pci_fifo_pkg.sv
// pci_fifo_pkg: shared FIFO size defaults and flag-bus bit ordering
package pci_fifo_pkg;
  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 2;
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction
  localparam int CNT_WIDTH_DEF = cnt_width(ADDR_WIDTH_DEF);
  localparam int N_FIFOS = 5;
  typedef enum logic [2:0] {
    FIFO_IDX_MAIN = 3'd0,
    FIFO_IDX_VC0  = 3'd1,
    FIFO_IDX_VC1  = 3'd2,
    FIFO_IDX_D0   = 3'd3,
    FIFO_IDX_D1   = 3'd4
  } fifo_idx_e;
endpackage

// File: rtl/fifo_umbral_if.sv
// fifo_umbral_if: push/pop handshake, thresholds and status flags of one FIFO
interface fifo_umbral_if import pci_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) ();
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [CNT_WIDTH-1:0]  umbral_almost_full;
  logic [CNT_WIDTH-1:0]  umbral_almost_empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;
  logic [CNT_WIDTH-1:0]  count;
  modport master (
    output push, data_in, pop, umbral_almost_full, umbral_almost_empty,
    input  data_out, valid_out, fifo_empty, fifo_full, almost_full, almost_empty, fifo_error, count
  );
  modport slave (
    input  push, data_in, pop, umbral_almost_full, umbral_almost_empty,
    output data_out, valid_out, fifo_empty, fifo_full, almost_full, almost_empty, fifo_error, count
  );
endinterface

// File: rtl/fifo_umbral_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH register file, one sync write and one registered read port
module fifo_mem #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // storage array carries no reset; contents are meaningless until written
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // read register holds the last popped word until the next accepted pop
  always_ff @(posedge clk or posedge reset)
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/fifo_umbral.sv
// fifo_umbral: threshold FIFO with sticky error flag; FIFO_HIGHWATER_EN adds max_count peak tracking
module fifo_umbral import pci_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_umbral_if.slave         bus
`ifdef FIFO_HIGHWATER_EN
  ,
  output logic [CNT_WIDTH-1:0] max_count
`endif
);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(2**ADDR_WIDTH);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  count, count_nx;
  logic                  pop_acc, push_acc, valid, err;
  assign pop_acc  = bus.pop && count != '0;
  assign push_acc = bus.push && (count != FULL || pop_acc);
  assign count_nx = count + CNT_WIDTH'(push_acc) - CNT_WIDTH'(pop_acc);
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk(clk), .reset(reset),
    .wr_en(push_acc), .wr_addr(wr_ptr), .wr_data(bus.data_in),
    .rd_en(pop_acc), .rd_addr(rd_ptr), .rd_data(bus.data_out)
  );
  // pointers, occupancy, read-valid pulse and sticky error on any rejected request
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(push_acc);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(pop_acc);
      count  <= count_nx;
      valid  <= pop_acc;
      err    <= err | (bus.push && !push_acc) | (bus.pop && !pop_acc);
    end
`ifdef FIFO_HIGHWATER_EN
  // peak occupancy since reset, tracked on the same edge as count
  always_ff @(posedge clk or posedge reset)
    if (reset) max_count <= '0;
    else if (count_nx > max_count) max_count <= count_nx;
`endif
  assign bus.count        = count;
  assign bus.valid_out    = valid;
  assign bus.fifo_error   = err;
  assign bus.fifo_empty   = count == '0;
  assign bus.fifo_full    = count == FULL;
  assign bus.almost_full  = count >= bus.umbral_almost_full;
  assign bus.almost_empty = count <= bus.umbral_almost_empty;
endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: queue-model bench with directed scenarios and randomized traffic
module tb_fifo_umbral;
  import pci_fifo_pkg::*;
  localparam int DW = 6, AW = 2, CW = 3, DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  fifo_umbral_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
`ifdef FIFO_HIGHWATER_EN
  logic [CW-1:0] max_count;
`endif
  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FIFO_HIGHWATER_EN
    ,
    .max_count(max_count)
`endif
  );
  always #5 clk = ~clk;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_data;
  logic m_valid, m_err;
  int m_max;
  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    q.delete();
    m_data = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_max = 0;
  endtask
  // one clock of traffic; the model applies the acceptance rules to the pre-edge inputs
  task automatic step(input logic p, input logic [DW-1:0] d, input logic o);
    logic pa, wa;
    bus.push = p;
    bus.data_in = d;
    bus.pop = o;
    @(posedge clk);
    pa = o && q.size() > 0;
    wa = p && (q.size() < DEPTH || pa);
    m_valid = pa;
    if (pa) m_data = q.pop_front();
    if (wa) q.push_back(d);
    if ((p && !wa) || (o && !pa)) m_err = 1'b1;
    if (q.size() > m_max) m_max = q.size();
    #2;
  endtask
  // asynchronous reset assertion checked before any clock edge, released away from edges
  task automatic do_reset();
    bus.push = 1'b0;
    bus.pop = 1'b0;
    reset = 1'b1;
    model_clear();
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_error", bus.fifo_error, 0);
    chk("rst_empty", bus.fifo_empty, 1);
    chk("rst_full", bus.fifo_full, 0);
`ifdef FIFO_HIGHWATER_EN
    chk("rst_max", max_count, 0);
`endif
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask
  // per-cycle comparison of every output against the queue model
  always @(negedge clk)
    if (!reset) begin
      chk("count", bus.count, q.size());
      chk("empty", bus.fifo_empty, q.size() == 0);
      chk("full", bus.fifo_full, q.size() == DEPTH);
      chk("almost_full", bus.almost_full, q.size() >= int'(bus.umbral_almost_full));
      chk("almost_empty", bus.almost_empty, q.size() <= int'(bus.umbral_almost_empty));
      chk("error", bus.fifo_error, m_err);
      chk("valid", bus.valid_out, m_valid);
      chk("data_out", bus.data_out, m_data);
`ifdef FIFO_HIGHWATER_EN
      chk("max_count", max_count, m_max);
`endif
    end
  initial begin
    logic [1:0] ae_lit [4];
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    bus.umbral_almost_full = 3'd3;
    bus.umbral_almost_empty = 3'd1;
    model_clear();
    #2;
    do_reset();
    chk("lit_ae0", bus.almost_empty, 1);
    chk("lit_af0", bus.almost_full, 0);
    ae_lit = '{2'b10, 2'b00, 2'b01, 2'b01};
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, DW'(i), 1'b0);
      chk("lit_fill_ae", bus.almost_empty, ae_lit[i-1][1]);
      chk("lit_fill_af", bus.almost_full, ae_lit[i-1][0]);
    end
    chk("lit_fill_count", bus.count, 4);
    chk("lit_fill_full", bus.fifo_full, 1);
    chk("lit_fill_empty", bus.fifo_empty, 0);
    chk("lit_fill_err", bus.fifo_error, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, '0, 1'b1);
      chk("lit_pop_data", bus.data_out, i);
      chk("lit_pop_valid", bus.valid_out, 1);
    end
    step(1'b0, '0, 1'b0);
    chk("lit_idle_valid", bus.valid_out, 0);
    chk("lit_drained_empty", bus.fifo_empty, 1);
    chk("lit_drained_count", bus.count, 0);
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 6'h3F, 1'b0);
    chk("lit_ovf_err", bus.fifo_error, 1);
    chk("lit_ovf_count", bus.count, 4);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, '0, 1'b1);
      chk("lit_ovf_pop", bus.data_out, i);
    end
    chk("lit_ovf_sticky", bus.fifo_error, 1);
    do_reset();
    step(1'b1, 6'h15, 1'b1);
    chk("lit_pp_empty_count", bus.count, 1);
    chk("lit_pp_empty_err", bus.fifo_error, 1);
    chk("lit_pp_empty_valid", bus.valid_out, 0);
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b1, 6'h2A, 1'b1);
    chk("lit_pp_full_count", bus.count, 4);
    chk("lit_pp_full_err", bus.fifo_error, 0);
    chk("lit_pp_full_data", bus.data_out, 1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    chk("lit_pp_full_last", bus.data_out, 6'h2A);
    do_reset();
    step(1'b1, 6'h20, 1'b0);
    step(1'b1, 6'h21, 1'b0);
    chk("lit_wrap_count2", bus.count, 2);
    for (int i = 2; i < 10; i++) begin
      step(1'b1, DW'(6'h20 + i), 1'b1);
      chk("lit_wrap_data", bus.data_out, 6'h20 + i - 2);
      chk("lit_wrap_count", bus.count, 2);
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("lit_wrap_tail", bus.data_out, 6'h29);
    chk("lit_wrap_err", bus.fifo_error, 0);
`ifdef FIFO_HIGHWATER_EN
    chk("lit_wrap_max", max_count, 2);
`endif
    for (int i = 0; i < 3; i++) step(1'b1, DW'(i + 7), 1'b0);
    step(1'b0, '0, 1'b1);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 60 == 59) do_reset();
      if (n % 17 == 0) begin
        bus.umbral_almost_full = CW'($urandom_range(0, 7));
        bus.umbral_almost_empty = CW'($urandom_range(0, 7));
      end
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end
    step(1'b0, '0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
